// File: rtl/rip_bp_table_ctrl_pkg.sv
// Shared branch-predictor constants: table geometry defaults, 2-bit counter
// encodings and the write-port controller state type.
package rip_branch_predictor_const;

  localparam int unsigned DEF_TABLE_DEPTH = 10;
  localparam int unsigned DEF_TABLE_WIDTH = 2;

  typedef logic [DEF_TABLE_DEPTH-1:0] bp_index_t;

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'd0,
    WEAKLY_UNTAKEN   = 2'd1,
    WEAKLY_TAKEN     = 2'd2,
    STRONGLY_TAKEN   = 2'd3
  } bp_weight_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/rip_bp_table_ctrl_if.sv
// Update handshake plus table write port of the predictor table controller.
interface rip_bp_table_ctrl_if #(
  parameter int unsigned TABLE_DEPTH = 10,
  parameter int unsigned TABLE_WIDTH = 2
);
  logic                   upd_valid;
  logic                   upd_ready;
  logic [TABLE_DEPTH-1:0] upd_index;
  logic [TABLE_WIDTH-1:0] upd_data;
  logic                   wr_en;
  logic [TABLE_DEPTH-1:0] wr_addr;
  logic [TABLE_WIDTH-1:0] wr_data;

  modport master (
    output upd_valid, upd_index, upd_data,
    input  upd_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  upd_valid, upd_index, upd_data,
    output upd_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rip_bp_table_ctrl_fifo.sv
// Small synchronous update FIFO; count is combinational so it is valid in the
// same cycle a clear is applied.
module rip_bp_update_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/rip_bp_table_ctrl.sv
// Branch-predictor table write-port controller: initialisation sweep after
// reset/flush, then FIFO-buffered predictor updates at one write per cycle.
module rip_bp_table_ctrl
  import rip_branch_predictor_const::*;
#(
  parameter int unsigned           TABLE_DEPTH = DEF_TABLE_DEPTH,
  parameter int unsigned           TABLE_WIDTH = DEF_TABLE_WIDTH,
  parameter logic [TABLE_WIDTH-1:0] INIT_VALUE = TABLE_WIDTH'(WEAKLY_UNTAKEN),
  parameter int unsigned           FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush_req,
  rip_bp_table_ctrl_if.slave  bus,
  output logic                busy,
  output logic [7:0]          drop_cnt
);
  localparam int unsigned CW = TABLE_DEPTH + 1;
  localparam int unsigned FW = TABLE_DEPTH + TABLE_WIDTH;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'((2 ** TABLE_DEPTH) - 1);

  ctrl_state_t     state;
  logic [CW-1:0]   cnt;
  logic            run;
  logic            push;
  logic            pop;
  logic            fifo_push;
  logic [FW-1:0]   head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic [AW:0]     occ_next;
  logic [15:0]     drop_sum;

  assign run       = (state == RUN);
  assign push      = run && bus.upd_valid && bus.upd_ready;
  assign pop       = run && !fifo_empty && !flush_req;
  assign fifo_push = push && !flush_req && (!fifo_full || pop);
  assign occ_next  = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(pop);
  // Entries still queued plus a push landing in the flush cycle are all lost.
  assign drop_sum  = 16'(drop_cnt) + 16'(fifo_count) + 16'(push);

  rip_bp_update_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (pop),
    .clear (flush_req),
    .wdata ({bus.upd_index, bus.upd_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= CLEAR;
      cnt           <= '0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.upd_ready <= 1'b0;
      busy          <= 1'b1;
      drop_cnt      <= '0;
    end else if (flush_req) begin
      // Address 0 is written in the flush edge itself, so the sweep resumes at 1.
      if (run) drop_cnt <= (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
      state         <= CLEAR;
      cnt           <= CW'(1);
      bus.wr_en     <= 1'b1;
      bus.wr_addr   <= '0;
      bus.wr_data   <= INIT_VALUE;
      bus.upd_ready <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          bus.wr_en     <= 1'b1;
          bus.wr_addr   <= cnt[TABLE_DEPTH-1:0];
          bus.wr_data   <= INIT_VALUE;
          bus.upd_ready <= 1'b0;
          busy          <= 1'b1;
          cnt           <= cnt + 1'b1;
          if (cnt == LAST) state <= RUN;
        end
        RUN: begin
          bus.wr_en     <= pop;
          if (pop) begin
            bus.wr_addr <= head[FW-1:TABLE_WIDTH];
            bus.wr_data <= head[TABLE_WIDTH-1:0];
          end
          bus.upd_ready <= (occ_next != (AW+1)'(FIFO_DEPTH));
          busy          <= 1'b0;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_rip_bp_table_ctrl.sv
// Randomised bench for rip_bp_table_ctrl with a queue-based reference model
// and a decoupled write-port scoreboard.
module tb_rip_bp_table_ctrl;
  localparam int TD      = 4;
  localparam int TW      = 2;
  localparam int FD      = 4;
  localparam int ENTRIES = 16;
  localparam int INIT_V  = 1;

  typedef struct { int addr; int data; } wr_t;

  logic       clk;
  logic       rstn;
  logic       flush_req;
  logic       busy;
  logic [7:0] drop_cnt;

  rip_bp_table_ctrl_if #(.TABLE_DEPTH(TD), .TABLE_WIDTH(TW)) bus ();

  rip_bp_table_ctrl #(
    .TABLE_DEPTH (TD),
    .TABLE_WIDTH (TW),
    .INIT_VALUE  (2'd1),
    .FIFO_DEPTH  (FD)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush_req (flush_req),
    .bus       (bus),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table is either sweeping (position m_pos) or running with
  // a plain queue of accepted updates; one table write per cycle.
  wr_t exp_q[$];
  wr_t upd_q[$];
  bit  m_run;
  int  m_pos;
  bit  m_wr;
  bit  m_busy;
  bit  m_ready;
  int  m_drop;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q.delete();
      upd_q.delete();
      m_run = 0; m_pos = 0; m_wr = 0; m_busy = 1; m_ready = 0; m_drop = 0;
    end else begin
      bit  accept;
      wr_t w;
      accept = m_run && bus.upd_valid && m_ready;
      if (flush_req) begin
        if (m_run) begin
          m_drop = m_drop + upd_q.size() + (accept ? 1 : 0);
          if (m_drop > 255) m_drop = 255;
        end
        upd_q.delete();
        m_run = 0; m_pos = 1;
        w.addr = 0; w.data = INIT_V; exp_q.push_back(w);
        m_wr = 1; m_busy = 1; m_ready = 0;
      end else if (!m_run) begin
        w.addr = m_pos; w.data = INIT_V; exp_q.push_back(w);
        m_wr = 1; m_busy = 1; m_ready = 0;
        if (m_pos == ENTRIES - 1) m_run = 1;
        m_pos++;
      end else begin
        m_busy = 0;
        if (upd_q.size() > 0) begin
          exp_q.push_back(upd_q.pop_front());
          m_wr = 1;
        end else begin
          m_wr = 0;
        end
        if (accept) begin
          w.addr = int'(bus.upd_index); w.data = int'(bus.upd_data);
          upd_q.push_back(w);
        end
        m_ready = (upd_q.size() < FD);
      end
    end
  end

  always @(negedge clk) begin
    check("wr_en", int'(bus.wr_en), int'(m_wr));
    check("busy", int'(busy), int'(m_busy));
    check("upd_ready", int'(bus.upd_ready), int'(m_ready));
    check("drop_cnt", int'(drop_cnt), m_drop);
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", int'(bus.wr_addr), e.addr);
        check("wr_data", int'(bus.wr_data), e.data);
      end
    end
    check("exp_backlog_bounded", int'(exp_q.size() <= 1), 1);
  end

  task automatic idle(input int n);
    bus.upd_valid = 1'b0;
    flush_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    flush_req = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_index = '0;
    bus.upd_data = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(20);

    // Single update
    bus.upd_valid = 1'b1; bus.upd_index = 4'd3; bus.upd_data = 2'd2;
    @(negedge clk);
    idle(5);

    // Back-to-back updates 1..5
    for (int i = 1; i <= 5; i++) begin
      bus.upd_valid = 1'b1; bus.upd_index = 4'(i); bus.upd_data = 2'(i);
      @(negedge clk);
    end
    idle(4);

    // Flush while an update is queued and another is offered
    bus.upd_valid = 1'b1; bus.upd_index = 4'd7; bus.upd_data = 2'd3;
    @(negedge clk);
    bus.upd_index = 4'd8;
    flush_req = 1'b1;
    @(negedge clk);
    idle(9);
    flush_req = 1'b1;
    @(negedge clk);
    idle(20);

    // Random traffic with occasional flushes
    for (int c = 0; c < 2000; c++) begin
      bus.upd_valid = ($urandom_range(0, 3) != 0);
      bus.upd_index = 4'($urandom_range(0, 15));
      bus.upd_data  = 2'($urandom_range(0, 3));
      flush_req     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    idle(20);

    // Drive drop_cnt into saturation
    for (int k = 0; k < 150; k++) begin
      bus.upd_valid = 1'b1;
      bus.upd_index = 4'($urandom_range(0, 15));
      bus.upd_data  = 2'($urandom_range(0, 3));
      repeat (19) @(negedge clk);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
    end
    idle(20);

    // Asynchronous reset mid-RUN with updates in flight
    bus.upd_valid = 1'b1; bus.upd_index = 4'd9; bus.upd_data = 2'd0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_wr_en", int'(bus.wr_en), 0);
    check("async_busy", int'(busy), 1);
    check("async_drop", int'(drop_cnt), 0);
    check("async_ready", int'(bus.upd_ready), 0);
    bus.upd_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle(25);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
